// File: rtl/tartcfg.sv
// Shared configuration for the correlator readback path: default sizes,
// address field widths and the readback FSM state encoding.
package tartcfg;

    localparam int DEF_ACCUM = 24;  // visibility word width
    localparam int DEF_TRATE = 12;  // time-multiplex slots per correlator block
    localparam int DEF_NBLK  = 6;   // correlator blocks on the bus
    localparam int DEF_TMOUT = 15;  // WACK cycles allowed before giving up

    localparam int WORD_W = 3;
    localparam int SLOT_W = 4;
    localparam int BANK_W = 4;
    localparam int BLK_W  = 3;
    localparam int ADR_W  = BANK_W + SLOT_W + WORD_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WACK = 3'd2,
        ST_HOLD = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } rb_state_t;

    // Bus address layout: bank in the top bits, word index fastest.
    function automatic logic [ADR_W-1:0] make_adr(input logic [BANK_W-1:0] bank,
                                                  input logic [SLOT_W-1:0] slot,
                                                  input logic [WORD_W-1:0] word);
        return {bank, slot, word};
    endfunction

endpackage

// File: rtl/readback_counter.sv
// Nested word/slot/block counter for one readback sequence. Word runs
// fastest (0..7), then slot (0..TRATE-1), then block (0..NBLK-1).
// blk_last flags the final word of a block, tc the final word overall.
module readback_counter
    import tartcfg::*;
#(
    parameter int TRATE = DEF_TRATE,
    parameter int NBLK  = DEF_NBLK
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [WORD_W-1:0] word,
    output logic [SLOT_W-1:0] slot,
    output logic [BLK_W-1:0]  blk,
    output logic              blk_last,
    output logic              tc
);

    localparam logic [WORD_W-1:0] WORD_LAST = '1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TRATE - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(NBLK - 1);

    assign blk_last = (word == WORD_LAST) && (slot == SLOT_LAST);
    assign tc       = blk_last && (blk == BLK_LAST);

    // Advance the word/slot/block odometer; clr restarts a sequence.
    always_ff @(posedge clk_i) begin
        if (rst || clr) begin
            word <= '0;
            slot <= '0;
            blk  <= '0;
        end else if (adv) begin
            if (word != WORD_LAST) begin
                word <= word + 1'b1;
            end else begin
                word <= '0;
                if (slot != SLOT_LAST) begin
                    slot <= slot + 1'b1;
                end else begin
                    slot <= '0;
                    blk  <= (blk == BLK_LAST) ? '0 : blk + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/correlator_readback.sv
// Correlator readback master. Walks every word of every slot of every
// correlator block in one bank over a single-beat read bus, and streams
// each visibility word out on a valid/ready port.
//
// Output stream handshake: dat_o is offered while vld_o is high and is
// held unchanged until the cycle in which rdy_i is also high; that cycle
// transfers exactly one word. vld_o never drops without a transfer except
// on rst.
module correlator_readback
    import tartcfg::*;
#(
    parameter int ACCUM = DEF_ACCUM,
    parameter int TRATE = DEF_TRATE,
    parameter int NBLK  = DEF_NBLK,
    parameter int TMOUT = DEF_TMOUT
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic              start_i,
    input  logic [BANK_W-1:0] bank_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic              bst_o,
    output logic [ADR_W-1:0]  adr_o,
    output logic [BLK_W-1:0]  blk_o,
    input  logic              ack_i,
    input  logic [ACCUM-1:0]  dat_i,
    output logic [ACCUM-1:0]  dat_o,
    output logic              vld_o,
    input  logic              rdy_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overrun_o,
    output logic              err_o
);

    localparam int TMO_W = $clog2(TMOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMOUT - 1);

    rb_state_t         state;
    rb_state_t         state_nxt;
    logic [BANK_W-1:0] bank;
    logic [BANK_W-1:0] pend_bank;
    logic              pending;
    logic              overrun;
    logic              err;
    logic [ACCUM-1:0]  dat;
    logic [TMO_W-1:0]  tcnt;

    logic              cnt_clr;
    logic              cnt_adv;
    logic              cap;
    logic              tmo_hit;

    logic [WORD_W-1:0] word;
    logic [SLOT_W-1:0] slot;
    logic [BLK_W-1:0]  blk;
    logic              blk_last;
    logic              tc;

    readback_counter #(
        .TRATE (TRATE),
        .NBLK  (NBLK)
    ) u_counter (
        .clk_i    (clk_i),
        .rst      (rst),
        .clr      (cnt_clr),
        .adv      (cnt_adv),
        .word     (word),
        .slot     (slot),
        .blk      (blk),
        .blk_last (blk_last),
        .tc       (tc)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the per-cycle strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_adv   = 1'b0;
        cap       = 1'b0;
        tmo_hit   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending || start_i) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                state_nxt = ST_WACK;
            end
            ST_WACK: begin
                if (ack_i) begin
                    cap       = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (tcnt == TMO_LAST) begin
                    // Slave is dead: abandon the whole sequence.
                    tmo_hit   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (rdy_i) begin
                    state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (tc) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_adv   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request intake: a start while busy parks in a one-deep pending slot,
    // a second start while that slot is full flags overrun (latest bank wins).
    always_ff @(posedge clk_i) begin
        if (rst) begin
            bank      <= '0;
            pend_bank <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
        end else if (state == ST_IDLE) begin
            if (pending) begin
                bank    <= pend_bank;
                pending <= start_i;
                if (start_i) begin
                    pend_bank <= bank_i;
                end
            end else if (start_i) begin
                bank <= bank_i;
            end
        end else if (start_i) begin
            pending   <= 1'b1;
            pend_bank <= bank_i;
            if (pending) begin
                overrun <= 1'b1;
            end
        end
    end

    // Ack timeout counter, read data capture and the sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            tcnt <= '0;
            dat  <= '0;
            err  <= 1'b0;
        end else begin
            if (state == ST_REQ) begin
                tcnt <= '0;
            end else if (state == ST_WACK) begin
                tcnt <= tcnt + 1'b1;
            end
            if (cap) begin
                dat <= dat_i;
            end
            if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign cyc_o     = (state == ST_REQ) || (state == ST_WACK) || (state == ST_HOLD);
    assign stb_o     = (state == ST_REQ);
    assign we_o      = 1'b0;
    assign bst_o     = cyc_o && !blk_last;
    assign adr_o     = make_adr(bank, slot, word);
    assign blk_o     = blk;
    assign dat_o     = dat;
    assign vld_o     = (state == ST_HOLD);
    assign done_o    = (state == ST_DONE);
    assign busy_o    = (state != ST_IDLE) || pending;
    assign overrun_o = overrun;
    assign err_o     = err;

endmodule

// File: doc/correlator_readback.md
CORRELATOR_READBACK -- requirements
Module: correlator_readback

Interface
REQ-001 SHALL have parameter ACCUM, default 24, visibility word width.
REQ-002 SHALL have parameter TRATE, default 12, time-multiplex slots per correlator block.
REQ-003 SHALL have parameter NBLK, default 6, number of correlator blocks on the bus.
REQ-004 SHALL have parameter TMOUT, default 15, ack-timeout cycles.
REQ-005 SHALL have ports: clk_i input 1 bus clock; rst input 1 reset, synchronous, active-high; clock clk_i.
REQ-006 SHALL have ports: start_i input 1 readback request pulse; bank_i input 4 bank index to read.
REQ-007 SHALL have ports: cyc_o output 1, stb_o output 1, we_o output 1 (tied 0), bst_o output 1, adr_o output 11 {bank,slot,word}, blk_o output 3 block index, ack_i input 1, dat_i input ACCUM.
REQ-008 SHALL have ports: dat_o output ACCUM, vld_o output 1, rdy_i input 1 (stream out); busy_o, done_o, overrun_o, err_o outputs 1.

Function
REQ-009 SHALL use states IDLE, REQ, WACK, HOLD, NEXT, DONE.
REQ-010 IDLE: start_i or pending -> latch bank_i (or pending bank), clear counters, go REQ; busy_o high from the next cycle.
REQ-011 REQ: cyc_o=1, stb_o=1 for exactly one cycle, then WACK; cyc_o stays high from REQ through HOLD.
REQ-012 WACK: ack_i -> capture dat_i into dat_o, go HOLD; timeout counter reaching TMOUT without ack -> set err_o sticky, drop cyc_o, go IDLE, abandon the sequence.
REQ-013 HOLD: vld_o=1 and dat_o stable until rdy_i; on vld_o&&rdy_i go NEXT.
REQ-014 NEXT: word 0..7 fastest, then slot 0..TRATE-1, then blk 0..NBLK-1; last word (7, TRATE-1, NBLK-1) -> DONE, else REQ.
REQ-015 DONE: done_o high one cycle, cyc_o low, then IDLE; busy_o low in IDLE with no pending request.
REQ-016 adr_o = {bank,slot[3:0],word[2:0]}; blk_o = block counter; both stable from REQ through HOLD.
REQ-017 bst_o SHALL be high in REQ/WACK/HOLD except for the final word of each block.
REQ-018 start_i while busy SHALL set pending and store bank_i (later start overwrites bank); start_i while pending already set SHALL set overrun_o sticky.
REQ-019 start_i in the DONE cycle SHALL be treated as pending and serviced immediately after IDLE.
REQ-020 Minimum per word is 5 cycles (REQ, WACK x2, HOLD, NEXT) with a 2-cycle slave ack and rdy_i held high; a sequence totals NBLK*TRATE*8 words (576 by default).
REQ-021 ack_i outside WACK SHALL be ignored.
REQ-022 Sticky flags SHALL clear only on rst.

Reset
REQ-023 rst SHALL force IDLE and clear pending; at reset, cyc_o, stb_o, bst_o, vld_o, busy_o, done_o, overrun_o and err_o are 0, adr_o, blk_o and dat_o are 0, and counters are cleared.
REQ-024 rst mid-sequence SHALL drop cyc_o/stb_o on the next edge with no further words emitted.

Structure
REQ-025 ACCUM, TRATE, NBLK, field widths (word 3, slot 4, bank 4, blk 3) and the state encoding SHALL live in the shared tartcfg package.
REQ-026 One sub-module readback_counter SHALL hold the nested word/slot/blk counter with a terminal-count output; the FSM stays in the top module.

Verification
REQ-027 Bench SHALL cover: start_i with bank_i=3, slave ack after 2 cycles, rdy_i=1 -> 576 words, adr_o of the first word 0x180 and last 0x1DF, blk_o 0..5, one done_o, total 2880 cycles.
REQ-028 Bench SHALL cover: rdy_i toggled 1/0 per cycle -> dat_o held while vld_o&&!rdy_i, no word lost or duplicated versus the slave model.
REQ-029 Bench SHALL cover: start_i (bank 1) mid-sequence, then start_i (bank 2) -> overrun_o=1, second sequence reads bank 2 immediately after done_o.
REQ-030 Bench SHALL cover: slave never acks word 10 -> err_o=1 after 15 WACK cycles, cyc_o=0, busy_o=0.
REQ-031 Bench SHALL cover: rst asserted in HOLD of word 100 -> all outputs 0 next cycle, a fresh start_i restarts from adr word 0 and blk 0.
